// File: rtl/mapu_mstream_arb_pkg.sv
// Shared types and default parameters for the mstream round-robin arbiter.
package mapu_mstream_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 256;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } mstream_arb_state_t;

endpackage

// File: rtl/mapu_mstream_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module mapu_mstream_rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned pos;

  // Scan from the far end down so the lowest rotated offset wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = (32'(ptr) + 32'(k)) % NUM_REQ;
      if (req[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/mapu_mstream_arb.sv
// Round-robin arbiter locking one mstream output to a source for a whole matrix.
// Optional stall timeout enabled by defining MAPU_MSTREAM_ARB_TIMEOUT_EN.
module mapu_mstream_arb
  import mapu_mstream_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_vld,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_eom,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_eom,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  mstream_arb_state_t state, state_nxt;
  logic [IDX_W-1:0]   gnt, gnt_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   gnt_inc;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               locked;
  logic               src_vld;
  logic               src_eom;
  logic [DATA_W-1:0]  src_data;
  logic               beat_done;
  logic               stall_fire;

  mapu_mstream_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req   (req_vld),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Zero-latency pass-through of the granted source while locked.
  assign locked    = (state == LOCK);
  assign src_vld   = req_vld[gnt];
  assign src_eom   = req_eom[gnt];
  assign src_data  = req_data[32'(gnt) * DATA_W +: DATA_W];
  assign out_vld   = locked & src_vld;
  assign out_eom   = locked & src_eom;
  assign out_data  = locked ? src_data : '0;
  assign beat_done = out_vld & out_rdy;
  assign out_src   = gnt;
  assign busy      = locked;
  assign gnt_inc   = (32'(gnt) == NUM_REQ - 1) ? '0 : IDX_W'(gnt + IDX_W'(1));

  always_comb begin
    req_rdy = '0;
    if (locked) req_rdy[gnt] = out_rdy;
  end

`ifdef MAPU_MSTREAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_err_q;

  // Fires on the cycle the count of source-side stalls reaches TIMEOUT.
  assign stall_fire  = locked & ~src_vld & (stall_cnt == CNT_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= stall_fire;
      if (!locked || beat_done || stall_fire) stall_cnt <= '0;
      else if (!src_vld)                      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign stall_fire     = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Grant held until the eom beat is accepted (or a forced release).
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = LOCK;
          gnt_nxt   = pick_idx;
        end
      end
      LOCK: begin
        if ((beat_done && src_eom) || stall_fire) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
